camera_ycbcr_capture: RTL and testbench

//  Captures YCbCr 4:2:2 byte stream (Cb,Y0,Cr,Y1) from camera port; emits one framebuffer write per pixel (both Y samples).

---
 rtl/camera_ycbcr_capture.sv | 255 +++++++++++++++++++++++++
 tb/tb_camera_ycbcr_capture.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_ycbcr_capture.sv
// Camera capture front end: takes a YCbCr 4:2:2 byte stream (Cb,Y0,Cr,Y1),
// writes one framebuffer pixel per Y sample as gray, RGB or threshold overlay,
// and reports a per-frame count and bounding box of threshold matches.
//
// Handshake: there is no back-pressure. wren is a one-pclk strobe qualifying
// wr_x/wr_y/rgb, and det_valid is a one-pclk strobe qualifying det_* and line_err;
// a consumer must accept on the cycle the strobe is high.
module camera_ycbcr_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CH_BITS  = 3
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic                   cam_vsync,
    input  logic                   href,
    input  logic [7:0]             pixel,
    input  logic [1:0]             mode,
    input  logic [7:0]             y_thr,
    input  logic [7:0]             cb_thr,
    input  logic [7:0]             cr_thr,
    output logic                   wren,
    output logic [9:0]             wr_x,
    output logic [9:0]             wr_y,
    output logic [3*CH_BITS-1:0]   rgb,
    output logic                   det_valid,
    output logic [19:0]            det_count,
    output logic [9:0]             det_xmin,
    output logic [9:0]             det_xmax,
    output logic [9:0]             det_ymin,
    output logic [9:0]             det_ymax,
    output logic                   det_found,
    output logic                   line_err
);

    // Counters are one bit wider than the coordinate outputs so that long
    // lines/frames saturate instead of wrapping back into the visible window.
    localparam logic [10:0]        H_LIM   = 11'(H_ACTIVE);
    localparam logic [10:0]        V_LIM   = 11'(V_ACTIVE);
    localparam logic [CH_BITS-1:0] CH_ONES = '1;
    localparam logic [CH_BITS-1:0] CH_ZERO = '0;

    typedef enum logic [1:0] {
        WAIT_VSYNC_UP   = 2'd0,
        WAIT_VSYNC_DOWN = 2'd1,
        ACTIVE          = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   phase;
    logic         byte_seen;
    logic [10:0]  x_cnt;
    logic [10:0]  y_cnt;
    logic [7:0]   cb_r;
    logic [7:0]   cr_r;
    logic [7:0]   y0_r;

    // Per-frame copies of the runtime controls, frozen at frame start.
    logic [1:0]   mode_s;
    logic [7:0]   y_thr_s;
    logic [7:0]   cb_thr_s;
    logic [7:0]   cr_thr_s;

    // Detection accumulators for the frame in progress.
    logic [19:0]  acc_count;
    logic [9:0]   acc_xmin;
    logic [9:0]   acc_xmax;
    logic [9:0]   acc_ymin;
    logic [9:0]   acc_ymax;
    logic         acc_err;

    logic [7:0]            pix_y;
    logic [7:0]            pix_cb;
    logic [7:0]            pix_cr;
    logic signed [17:0]    y_s;
    logic signed [17:0]    d_s;
    logic signed [17:0]    e_s;
    logic signed [17:0]    r_s;
    logic signed [17:0]    g_s;
    logic signed [17:0]    b_s;
    logic [CH_BITS-1:0]    gray_ch;
    logic                  pix_match;
    logic                  in_window;
    logic [3*CH_BITS-1:0]  pix_rgb;

    // Clamp a converted channel to 0..255 and keep its top CH_BITS bits.
    function automatic logic [CH_BITS-1:0] top_bits(input logic signed [17:0] v);
        if (v < 18'sd0) begin
            return CH_ZERO;
        end else if (v > 18'sd255) begin
            return CH_ONES;
        end else begin
            return v[7 -: CH_BITS];
        end
    endfunction

    // Colour of the pixel being emitted this cycle: at phase 2 it is Y0 with the
    // Cr on the bus, at phase 3 it is Y1 with the stored Cb/Cr of the group.
    always_comb begin
        pix_y  = pixel;
        pix_cb = cb_r;
        pix_cr = cr_r;
        if (phase == 2'd2) begin
            pix_y  = y0_r;
            pix_cr = pixel;
        end
        y_s = $signed({10'd0, pix_y});
        d_s = $signed({10'd0, pix_cb}) - 18'sd128;
        e_s = $signed({10'd0, pix_cr}) - 18'sd128;
        r_s = y_s + ((18'sd359 * e_s) >>> 8);
        g_s = y_s - ((18'sd88 * d_s + 18'sd183 * e_s) >>> 8);
        b_s = y_s + ((18'sd454 * d_s) >>> 8);
        gray_ch   = pix_y[7 -: CH_BITS];
        pix_match = (pix_y > y_thr_s) && (pix_cb > cb_thr_s) && (pix_cr > cr_thr_s);
        in_window = (x_cnt < H_LIM) && (y_cnt < V_LIM);
        case (mode_s)
            2'd1: pix_rgb = {top_bits(r_s), top_bits(g_s), top_bits(b_s)};
            2'd2: begin
                if (!pix_match) begin
                    pix_rgb = {gray_ch, gray_ch, gray_ch};
                end else if (acc_count == 20'd0) begin
                    pix_rgb = {CH_ONES, CH_ZERO, CH_ZERO};
                end else begin
                    pix_rgb = {CH_ZERO, CH_ONES, CH_ZERO};
                end
            end
            default: pix_rgb = {gray_ch, gray_ch, gray_ch};
        endcase
    end

    // Frame/line sequencing, byte capture, pixel writes and detection results.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_VSYNC_UP;
            phase     <= 2'd0;
            byte_seen <= 1'b0;
            x_cnt     <= 11'd0;
            y_cnt     <= 11'd0;
            cb_r      <= 8'd0;
            cr_r      <= 8'd0;
            y0_r      <= 8'd0;
            mode_s    <= 2'd0;
            y_thr_s   <= 8'd0;
            cb_thr_s  <= 8'd0;
            cr_thr_s  <= 8'd0;
            acc_count <= 20'd0;
            acc_xmin  <= 10'd0;
            acc_xmax  <= 10'd0;
            acc_ymin  <= 10'd0;
            acc_ymax  <= 10'd0;
            acc_err   <= 1'b0;
            wren      <= 1'b0;
            wr_x      <= 10'd0;
            wr_y      <= 10'd0;
            rgb       <= '0;
            det_valid <= 1'b0;
            det_count <= 20'd0;
            det_xmin  <= 10'd0;
            det_xmax  <= 10'd0;
            det_ymin  <= 10'd0;
            det_ymax  <= 10'd0;
            det_found <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            wren      <= 1'b0;
            det_valid <= 1'b0;
            case (state)
                WAIT_VSYNC_UP: begin
                    if (cam_vsync) state <= WAIT_VSYNC_DOWN;
                end
                WAIT_VSYNC_DOWN: begin
                    if (!cam_vsync) begin
                        // Frame start: freeze controls and start from an empty box.
                        state     <= ACTIVE;
                        mode_s    <= mode;
                        y_thr_s   <= y_thr;
                        cb_thr_s  <= cb_thr;
                        cr_thr_s  <= cr_thr;
                        phase     <= 2'd0;
                        byte_seen <= 1'b0;
                        x_cnt     <= 11'd0;
                        y_cnt     <= 11'd0;
                        acc_count <= 20'd0;
                        acc_xmin  <= 10'd1023;
                        acc_xmax  <= 10'd0;
                        acc_ymin  <= 10'd1023;
                        acc_ymax  <= 10'd0;
                        acc_err   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cam_vsync) begin
                        // Frame end, also aborting any line still in progress.
                        state     <= WAIT_VSYNC_DOWN;
                        det_valid <= 1'b1;
                        det_count <= acc_count;
                        det_xmin  <= acc_xmin;
                        det_xmax  <= acc_xmax;
                        det_ymin  <= acc_ymin;
                        det_ymax  <= acc_ymax;
                        det_found <= (acc_count != 20'd0);
                        line_err  <= acc_err;
                        acc_count <= 20'd0;
                        acc_xmin  <= 10'd1023;
                        acc_xmax  <= 10'd0;
                        acc_ymin  <= 10'd1023;
                        acc_ymax  <= 10'd0;
                        acc_err   <= 1'b0;
                        phase     <= 2'd0;
                        byte_seen <= 1'b0;
                        x_cnt     <= 11'd0;
                        y_cnt     <= 11'd0;
                    end else if (href) begin
                        byte_seen <= 1'b1;
                        phase     <= phase + 2'd1;
                        case (phase)
                            2'd0:    cb_r <= pixel;
                            2'd1:    y0_r <= pixel;
                            2'd2:    cr_r <= pixel;
                            default: ;
                        endcase
                        if (phase[1]) begin
                            if (x_cnt != 11'h7FF) x_cnt <= x_cnt + 11'd1;
                            if (in_window) begin
                                wren <= 1'b1;
                                wr_x <= x_cnt[9:0];
                                wr_y <= y_cnt[9:0];
                                rgb  <= pix_rgb;
                                if (pix_match) begin
                                    if (acc_count != 20'hFFFFF) acc_count <= acc_count + 20'd1;
                                    if (x_cnt[9:0] < acc_xmin) acc_xmin <= x_cnt[9:0];
                                    if (x_cnt[9:0] > acc_xmax) acc_xmax <= x_cnt[9:0];
                                    if (y_cnt[9:0] < acc_ymin) acc_ymin <= y_cnt[9:0];
                                    if (y_cnt[9:0] > acc_ymax) acc_ymax <= y_cnt[9:0];
                                end
                            end
                        end
                    end else begin
                        // First low href after any byte is the line end;
                        // partial Cb/Cr groups are simply dropped.
                        phase     <= 2'd0;
                        x_cnt     <= 11'd0;
                        byte_seen <= 1'b0;
                        if (byte_seen) begin
                            if (y_cnt != 11'h7FF) y_cnt <= y_cnt + 11'd1;
                            if (x_cnt != H_LIM) acc_err <= 1'b1;
                        end
                    end
                end
                default: state <= WAIT_VSYNC_UP;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_ycbcr_capture.sv
// Bench for camera_ycbcr_capture: drives whole frames of 4:2:2 bytes, predicts
// every framebuffer write and the per-frame detection result from a frame-level
// model, and compares them with the DUT.
module tb_camera_ycbcr_capture;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int CH = 3;
  localparam int RW = 3 * CH;
  localparam int W  = 20 + RW;

  logic          pclk = 1'b0;
  logic          reset = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    pixel = 8'd0;
  logic [1:0]    mode = 2'd0;
  logic [7:0]    y_thr = 8'd0;
  logic [7:0]    cb_thr = 8'd0;
  logic [7:0]    cr_thr = 8'd0;
  logic          wren;
  logic [9:0]    wr_x;
  logic [9:0]    wr_y;
  logic [RW-1:0] rgb;
  logic          det_valid;
  logic [19:0]   det_count;
  logic [9:0]    det_xmin;
  logic [9:0]    det_xmax;
  logic [9:0]    det_ymin;
  logic [9:0]    det_ymax;
  logic          det_found;
  logic          line_err;

  camera_ycbcr_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .CH_BITS(CH)) dut (
    .pclk(pclk), .reset(reset), .cam_vsync(cam_vsync), .href(href), .pixel(pixel),
    .mode(mode), .y_thr(y_thr), .cb_thr(cb_thr), .cr_thr(cr_thr),
    .wren(wren), .wr_x(wr_x), .wr_y(wr_y), .rgb(rgb),
    .det_valid(det_valid), .det_count(det_count),
    .det_xmin(det_xmin), .det_xmax(det_xmax), .det_ymin(det_ymin), .det_ymax(det_ymax),
    .det_found(det_found), .line_err(line_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 pclk = ~pclk;

  initial begin
    #900000;
    $error("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next predicted {x, y, rgb}.
  always @(negedge pclk) begin
    if (reset && wren) begin
      n_checks++;
      assert (exp_q.size() > 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL pixel_unexpected observed=x%0d,y%0d expected=no_write", wr_x, wr_y);
      end
      if (exp_q.size() > 0) check("pixel_write", {wr_x, wr_y, rgb}, exp_q.pop_front());
    end
  end

  // ---------------- frame description ----------------
  int         n_lines;
  int         npix[16];
  int         extra[16];
  bit         abort_last;
  logic [7:0] fy[16][32];
  logic [7:0] fcb[16][16];
  logic [7:0] fcr[16][16];
  int e_count, e_xmin, e_xmax, e_ymin, e_ymax, e_err;
  int nx_md, nx_yt, nx_cbt, nx_crt;

  // ---------------- reference model ----------------
  function automatic int fdiv256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int chan(input int v);
    int c;
    c = (v < 0) ? 0 : ((v > 255) ? 255 : v);
    return c >> (8 - CH);
  endfunction

  function automatic logic [RW-1:0] model_rgb(input int md, input int y, input int cb,
                                              input int cr, input bit m, input bit first);
    int gray, ones, d, e, r, g, b;
    gray = y >> (8 - CH);
    ones = (1 << CH) - 1;
    d = cb - 128;
    e = cr - 128;
    r = gray; g = gray; b = gray;
    if (md == 1) begin
      r = chan(y + fdiv256(359 * e));
      g = chan(y - fdiv256(88 * d + 183 * e));
      b = chan(y + fdiv256(454 * d));
    end else if (md == 2 && m) begin
      r = first ? ones : 0;
      g = first ? 0 : ones;
      b = 0;
    end
    return RW'((r << (2 * CH)) | (g << CH) | b);
  endfunction

  task automatic model_frame(input int md, input int yt, input int cbt, input int crt);
    int y, cb, cr;
    bit m;
    e_count = 0; e_xmin = 1023; e_xmax = 0; e_ymin = 1023; e_ymax = 0; e_err = 0;
    for (int l = 0; l < n_lines; l++) begin
      if (!(abort_last && l == n_lines - 1) && npix[l] != H) e_err = 1;
      for (int p = 0; p < npix[l]; p++) begin
        if (p < H && l < V) begin
          y = fy[l][p]; cb = fcb[l][p / 2]; cr = fcr[l][p / 2];
          m = (y > yt) && (cb > cbt) && (cr > crt);
          exp_q.push_back({10'(p), 10'(l), model_rgb(md, y, cb, cr, m, e_count == 0)});
          if (m) begin
            e_count++;
            if (p < e_xmin) e_xmin = p;
            if (p > e_xmax) e_xmax = p;
            if (l < e_ymin) e_ymin = l;
            if (l > e_ymax) e_ymax = l;
          end
        end
      end
    end
  endtask

  // ---------------- frame builders ----------------
  task automatic fill_uniform(input int nl, input int np, input int y, input int cb, input int cr);
    n_lines = nl;
    abort_last = 0;
    for (int l = 0; l < 16; l++) begin
      npix[l] = np;
      extra[l] = 0;
      for (int p = 0; p < 32; p++) fy[l][p] = 8'(y);
      for (int g = 0; g < 16; g++) begin
        fcb[l][g] = 8'(cb);
        fcr[l][g] = 8'(cr);
      end
    end
  endtask

  task automatic fill_random(input int nl);
    n_lines = nl;
    abort_last = 0;
    for (int l = 0; l < 16; l++) begin
      npix[l] = ($urandom_range(0, 3) == 0) ? 2 * int'($urandom_range(1, (H + 4) / 2)) : H;
      extra[l] = $urandom_range(0, 2);
      for (int p = 0; p < 32; p++) fy[l][p] = 8'($urandom_range(0, 255));
      for (int g = 0; g < 16; g++) begin
        fcb[l][g] = 8'($urandom_range(0, 255));
        fcr[l][g] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href  = 1'b1;
    pixel = b;
    step();
  endtask

  task automatic send_frame(input int md, input int yt, input int cbt, input int crt,
                            input bit mid_change, input int rst_line);
    bit saw_dv;
    mode = 2'(md); y_thr = 8'(yt); cb_thr = 8'(cbt); cr_thr = 8'(crt);
    href = 1'b0;
    cam_vsync = 1'b1;
    repeat (3) step();
    cam_vsync = 1'b0;
    repeat (2) step();
    for (int l = 0; l < n_lines; l++) begin
      if (mid_change && l == n_lines / 2) begin
        nx_md = $urandom_range(0, 3);
        nx_yt = $urandom_range(64, 192);
        nx_cbt = $urandom_range(64, 192);
        nx_crt = $urandom_range(64, 192);
        mode = 2'(nx_md); y_thr = 8'(nx_yt); cb_thr = 8'(nx_cbt); cr_thr = 8'(nx_crt);
      end
      for (int g = 0; g < npix[l] / 2; g++) begin
        send_byte(fcb[l][g]);
        send_byte(fy[l][2 * g]);
        send_byte(fcr[l][g]);
        send_byte(fy[l][2 * g + 1]);
        if (l == rst_line && g == 1) begin
          check("pre_reset_wren", wren, 1);
          reset = 1'b0;
          #1;
          check("rst_wren", wren, 0);
          check("rst_rgb", rgb, 0);
          check("rst_det_valid", det_valid, 0);
          check("rst_det_count", det_count, 0);
          check("rst_det_box", {det_xmin, det_xmax, det_ymin, det_ymax}, 0);
          check("rst_det_found", det_found, 0);
          check("rst_line_err", line_err, 0);
          exp_q.delete();
          href = 1'b0;
          repeat (2) step();
          reset = 1'b1;
          saw_dv = 0;
          for (int i = 0; i < 16; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            if (det_valid) saw_dv = 1;
          end
          href = 1'b0;
          repeat (3) step();
          check("no_det_after_reset", saw_dv, 0);
          return;
        end
      end
      if (abort_last && l == n_lines - 1) begin
        cam_vsync = 1'b1;
        step();
        return;
      end
      for (int i = 0; i < extra[l]; i++) send_byte(8'($urandom_range(0, 255)));
      href = 1'b0;
      repeat (3) step();
    end
    cam_vsync = 1'b1;
    step();
  endtask

  task automatic finish_frame(input bit chk_err);
    int waited;
    href = 1'b0;
    waited = 0;
    while (!det_valid && waited < 8) begin
      step();
      waited++;
    end
    check("det_valid_pulse", det_valid, 1);
    check("det_count", det_count, e_count);
    check("det_found", det_found, e_count != 0);
    check("det_box", {det_xmin, det_xmax, det_ymin, det_ymax},
          {10'(e_xmin), 10'(e_xmax), 10'(e_ymin), 10'(e_ymax)});
    if (chk_err) check("line_err", line_err, e_err);
    step();
    check("det_valid_single", det_valid, 0);
    check("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int md, input int yt, input int cbt, input int crt,
                           input bit mid_change, input bit chk_err);
    model_frame(md, yt, cbt, crt);
    send_frame(md, yt, cbt, crt, mid_change, -1);
    finish_frame(chk_err);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    repeat (3) step();
    check("reset_wren", wren, 0);
    check("reset_det_valid", det_valid, 0);
    check("reset_outputs", {wr_x, wr_y, rgb, det_count}, 0);
    check("reset_box", {det_xmin, det_xmax, det_ymin, det_ymax, det_found, line_err}, 0);
    reset = 1'b1;
    step();

    // Uniform gray frame: Y=200 -> 3'b110 on every channel, nothing matches.
    fill_uniform(V, H, 200, 128, 128);
    run_frame(0, 255, 255, 255, 0, 1);
    check("gray_found", det_found, 0);

    // Full conversion with R clamped high.
    fill_uniform(2, H, 128, 128, 255);
    run_frame(1, 255, 255, 255, 0, 1);

    // Overlay with a 4x2 matching patch at x=10..13, y=5..6.
    fill_uniform(V, H, 90, 100, 100);
    for (int l = 5; l <= 6; l++) begin
      for (int p = 10; p <= 13; p++) fy[l][p] = 8'd180;
      fcb[l][5] = 8'd200; fcb[l][6] = 8'd200;
      fcr[l][5] = 8'd200; fcr[l][6] = 8'd200;
    end
    run_frame(2, 100, 150, 150, 0, 1);
    check("patch_count", det_count, 8);
    check("patch_box", {det_xmin, det_xmax, det_ymin, det_ymax}, {10'd10, 10'd13, 10'd5, 10'd6});

    // One long and one short line flag line_err; a clean frame clears it.
    fill_uniform(V, H, 150, 140, 160);
    npix[1] = H + 2;
    npix[3] = H - 2;
    run_frame(0, 100, 100, 100, 0, 1);
    check("line_err_set", line_err, 1);
    fill_uniform(V, H, 150, 140, 160);
    run_frame(1, 100, 100, 100, 0, 1);
    check("line_err_clear", line_err, 0);

    // Controls changed mid-frame affect only the following frame.
    fill_random(V);
    run_frame(2, 120, 120, 120, 1, 1);
    fill_random(V);
    run_frame(nx_md, nx_yt, nx_cbt, nx_crt, 0, 1);

    // vsync rising during a line ends the frame normally.
    fill_random(4);
    abort_last = 1;
    npix[3] = 4;
    run_frame(2, 100, 100, 100, 0, 0);

    // Randomised frames, including extra lines beyond V and odd trailing bytes.
    for (int f = 0; f < 6; f++) begin
      fill_random($urandom_range(2, V + 1));
      run_frame($urandom_range(0, 3), $urandom_range(64, 192), $urandom_range(64, 192),
                $urandom_range(64, 192), 0, 1);
    end

    // Reset in the middle of a line, after a frame that left a nonzero box.
    fill_uniform(V, H, 200, 128, 128);
    run_frame(0, 255, 255, 255, 0, 1);
    fill_uniform(3, H, 200, 128, 128);
    model_frame(0, 255, 255, 255);
    send_frame(0, 255, 255, 255, 0, 1);

    // Capture resumes after a full vsync cycle.
    fill_random(V);
    run_frame(2, 90, 90, 90, 0, 1);

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
